// File: rtl/sig_meas_pkg.sv
// Shared definitions for the signal measurement blocks of the demod chain:
// default counter width, default loss-of-signal timeout and the counter type.
package sig_meas_pkg;

    localparam int CNT_W_DEF = 16;
    localparam logic [CNT_W_DEF-1:0] TIMEOUT_DEF = 16'd50000;

    typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage : sig_meas_pkg

// File: rtl/sig_sync_edge.sv
// Two-flop synchronizer for an asynchronous slow input, followed by a
// previous-value register so that single-cycle rise/fall strobes can be
// derived in the clk domain. Reusable by any block that watches a slow pin.
module sig_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic s3_q, s3_d;

    // Next-state of the synchronizer chain: each stage copies its predecessor.
    always_comb begin
        s1_d = async_in;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    // Synchronizer and previous-value flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign level = s2_q;
    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;

endmodule : sig_sync_edge

// File: rtl/sig_period_meter.sv
// Period meter for a slow square wave (divider output or demodulated bit
// clock). Reports the rise-to-rise period in clk cycles, pulses meas_valid on
// every valid measurement and raises los when no rise arrives within TIMEOUT.
// Optional feature macro: DUTY_MEAS_EN -- when defined the rise-to-fall time
// is also measured and published on high_time; otherwise high_time stays 0.
module sig_period_meter
    import sig_meas_pkg::*;
#(
    parameter int               CNT_W   = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             los
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic             level_s;
    logic             rise_s;
    logic             fall_s;
    logic             at_limit_s;
    logic [CNT_W-1:0] high_sample_s;
    logic             unused_s;

    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic             armed_q,      armed_d;
    logic             los_q,        los_d;
    logic [CNT_W-1:0] period_q,     period_d;
    logic [CNT_W-1:0] high_time_q,  high_time_d;
    logic             meas_valid_q, meas_valid_d;

    sig_sync_edge u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (sig_in),
        .level    (level_s),
        .rise     (rise_s),
        .fall     (fall_s)
    );

`ifdef DUTY_MEAS_EN
    logic [CNT_W-1:0] hi_lat_q,    hi_lat_d;
    logic             fall_seen_q, fall_seen_d;

    // Latch cycles-since-rise on each fall; a new rise starts a fresh high phase.
    always_comb begin
        hi_lat_d    = hi_lat_q;
        fall_seen_d = fall_seen_q;
        if (rise_s) begin
            fall_seen_d = 1'b0;
        end else if (fall_s) begin
            hi_lat_d    = cnt_q;
            fall_seen_d = 1'b1;
        end else begin
            hi_lat_d    = hi_lat_q;
            fall_seen_d = fall_seen_q;
        end
    end

    // High-time latch registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_lat_q    <= CNT_ZERO;
            fall_seen_q <= 1'b0;
        end else begin
            hi_lat_q    <= hi_lat_d;
            fall_seen_q <= fall_seen_d;
        end
    end

    // No fall between two rises means the input stayed high the whole period.
    assign high_sample_s = fall_seen_q ? hi_lat_q : cnt_q;
    assign unused_s      = level_s;
`else
    assign high_sample_s = CNT_ZERO;
    assign unused_s      = level_s ^ fall_s;
`endif

    assign at_limit_s = (cnt_q >= TIMEOUT);

    // Counter, arming, loss-of-signal and measurement publication.
    always_comb begin
        cnt_d        = cnt_q;
        armed_d      = armed_q;
        los_d        = los_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        if (rise_s) begin
            // A rise always restarts the count and re-arms; it beats a
            // coincident timeout, but a period equal to TIMEOUT is out of
            // range and is not published.
            cnt_d   = CNT_ONE;
            armed_d = 1'b1;
            los_d   = 1'b0;
            if (armed_q && !los_q && !at_limit_s) begin
                period_d     = cnt_q;
                high_time_d  = high_sample_s;
                meas_valid_d = 1'b1;
            end else begin
                period_d     = period_q;
                high_time_d  = high_time_q;
                meas_valid_d = 1'b0;
            end
        end else if (at_limit_s) begin
            cnt_d   = TIMEOUT;
            armed_d = 1'b0;
            los_d   = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Measurement state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q        <= CNT_ZERO;
            armed_q      <= 1'b0;
            los_q        <= 1'b0;
            period_q     <= CNT_ZERO;
            high_time_q  <= CNT_ZERO;
            meas_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            los_q        <= los_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign los        = los_q;

endmodule : sig_period_meter
